// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register for gap-free back-to-back frames.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd when PARITY_ODD=1).
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 256,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Ready,
    output logic       o_Tx_Active,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Done
);

    localparam int unsigned     CntW    = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntMax  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntDone = CntW'(CLKS_PER_BIT - 2);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_t;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;
`endif

    state_t          r_State;
    logic [CntW-1:0] r_Count;
    logic [2:0]      r_Bit_Index;
    logic [7:0]      r_Shift;
    logic [7:0]      r_Hold_Byte;
    logic            r_Hold_Valid;
    logic            r_Serial;
    logic            r_Active;
    logic            r_Done;

    logic w_Accept;
    logic w_Bit_End;

    assign w_Accept  = i_Tx_DV && !r_Hold_Valid;
    assign w_Bit_End = (r_Count == CntMax);

    assign o_Tx_Ready  = !r_Hold_Valid;
    assign o_Tx_Active = r_Active;
    assign o_Tx_Serial = r_Serial;
    assign o_Tx_Done   = r_Done;

    // Loading only happens while r_Hold_Valid is set, so it never coincides with an accept.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_State      <= StIdle;
            r_Count      <= '0;
            r_Bit_Index  <= '0;
            r_Shift      <= '0;
            r_Hold_Byte  <= '0;
            r_Hold_Valid <= 1'b0;
            r_Serial     <= 1'b1;
            r_Active     <= 1'b0;
            r_Done       <= 1'b0;
        end else begin
            r_Done <= 1'b0;
            if (w_Accept) begin
                r_Hold_Byte  <= i_Tx_Byte;
                r_Hold_Valid <= 1'b1;
            end
            case (r_State)
                StIdle: begin
                    if (r_Hold_Valid) begin
                        r_Shift      <= r_Hold_Byte;
                        r_Hold_Valid <= 1'b0;
                        r_Count      <= '0;
                        r_Serial     <= 1'b0;
                        r_Active     <= 1'b1;
                        r_State      <= StStart;
                    end
                end
                StStart: begin
                    if (w_Bit_End) begin
                        r_Count     <= '0;
                        r_Bit_Index <= '0;
                        r_Serial    <= r_Shift[0];
                        r_State     <= StData;
                    end else begin
                        r_Count <= r_Count + 1'b1;
                    end
                end
                StData: begin
                    if (w_Bit_End) begin
                        r_Count <= '0;
                        if (r_Bit_Index == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_Serial <= (^r_Shift) ^ PARITY_ODD;
                            r_State  <= StParity;
`else
                            r_Serial <= 1'b1;
                            r_State  <= StStop;
`endif
                        end else begin
                            r_Bit_Index <= r_Bit_Index + 3'd1;
                            r_Serial    <= r_Shift[r_Bit_Index + 3'd1];
                        end
                    end else begin
                        r_Count <= r_Count + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (w_Bit_End) begin
                        r_Count  <= '0;
                        r_Serial <= 1'b1;
                        r_State  <= StStop;
                    end else begin
                        r_Count <= r_Count + 1'b1;
                    end
                end
`endif
                StStop: begin
                    if (w_Bit_End) begin
                        r_Count <= '0;
                        if (r_Hold_Valid) begin
                            r_Shift      <= r_Hold_Byte;
                            r_Hold_Valid <= 1'b0;
                            r_Serial     <= 1'b0;
                            r_State      <= StStart;
                        end else begin
                            r_Serial <= 1'b1;
                            r_Active <= 1'b0;
                            r_State  <= StIdle;
                        end
                    end else begin
                        // Registered pulse lands on the final clock of the stop bit.
                        if (r_Count == CntDone) begin
                            r_Done <= 1'b1;
                        end
                        r_Count <= r_Count + 1'b1;
                    end
                end
                default: begin
                    r_State <= StIdle;
                end
            endcase
        end
    end

endmodule
